// File: rtl/swd_target.sv
// swd_target: target-side SWD responder. Oversamples swclk/swdio on clk, decodes request headers,
// returns ACK/read data/parity and captures write data. Line reset detection when SWDT_LINERESET_EN is defined.
module swd_target #(
  parameter int TURN = 1,
  parameter int SYNC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        swclk_in,
  input  logic        swdi,
  output logic        swdo,
  output logic        swdoe,
  output logic        req_valid,
  output logic        req_apndp,
  output logic        req_rnw,
  output logic [1:0]  req_addr32,
  input  logic        resp_valid,
  input  logic [2:0]  resp_ack,
  input  logic [31:0] resp_rdata,
  output logic        wr_valid,
  output logic [31:0] wr_data,
  output logic        wr_perr,
  output logic        line_reset,
  output logic        idle
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_TRN1, ST_ACK, ST_RDATA, ST_TRN2, ST_WDATA
  } state_t;

  localparam logic [5:0] L_TURN     = 6'(TURN);
  localparam logic [5:0] L_TURN_M1  = 6'(TURN - 1);
  localparam logic [2:0] L_ACK_OK   = 3'b001;
  localparam logic [2:0] L_ACK_WAIT = 3'b010;

  function automatic logic f_par32(input logic [31:0] d);
    return ^d;
  endfunction

  function automatic logic f_par4(input logic [3:0] d);
    return ^d;
  endfunction

  logic [SYNC-1:0] r_sclk_sync, r_sdi_sync;
  logic            r_sclk_d;
  logic            w_sclk, w_sdi, w_rise, w_fall;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_cnt, w_cnt_nxt;
  logic [5:0]  r_hdr, w_hdr_nxt;
  logic        r_wpar, w_wpar_nxt;
  logic [2:0]  r_ack, w_ack_nxt, w_ack_sel;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic [31:0] r_wshift, w_wshift_nxt;
  logic        r_swdo, w_swdo_nxt;
  logic        r_swdoe, w_swdoe_nxt;
  logic        r_req_valid, w_req_valid_nxt;
  logic        r_req_apndp, w_req_apndp_nxt;
  logic        r_req_rnw, w_req_rnw_nxt;
  logic [1:0]  r_req_addr, w_req_addr_nxt;
  logic        r_wr_valid, w_wr_valid_nxt;
  logic [31:0] r_wr_data, w_wr_data_nxt;
  logic        r_wr_perr, w_wr_perr_nxt;
  logic        r_line_reset, w_line_reset_nxt;
  logic        r_idle, w_idle_nxt;
  logic        w_wr_ok;
  logic        w_lr_fire, w_lr_hold;

  // Pin synchronisers plus the previous swclk level for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_sdi_sync  <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC-2:0], swclk_in};
      r_sdi_sync  <= {r_sdi_sync[SYNC-2:0], swdi};
      r_sclk_d    <= r_sclk_sync[SYNC-1];
    end
  end

  assign w_sclk = r_sclk_sync[SYNC-1];
  assign w_sdi  = r_sdi_sync[SYNC-1];
  assign w_rise = w_sclk & ~r_sclk_d;
  assign w_fall = ~w_sclk & r_sclk_d;

`ifdef SWDT_LINERESET_EN
  logic [5:0] r_lr_cnt, w_lr_cnt_nxt;
  logic       w_lr_zone;

  // Consecutive-ones counter; the target only listens in IDLE/HDR, so only those rises count
  always_comb begin
    w_lr_zone    = (r_state == ST_IDLE) || (r_state == ST_HDR);
    w_lr_cnt_nxt = r_lr_cnt;
    w_lr_fire    = 1'b0;
    if (w_rise && !w_sdi) begin
      w_lr_cnt_nxt = 6'd0;
    end else if (w_rise && w_lr_zone && (r_lr_cnt != 6'd63)) begin
      w_lr_cnt_nxt = r_lr_cnt + 6'd1;
      w_lr_fire    = (r_lr_cnt == 6'd49);
    end else begin
      w_lr_cnt_nxt = r_lr_cnt;
    end
  end

  // While the line is held in reset, ones are not start bits
  assign w_lr_hold = (r_lr_cnt >= 6'd50);

  // Line reset counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lr_cnt <= 6'd0;
    end else begin
      r_lr_cnt <= w_lr_cnt_nxt;
    end
  end
`else
  assign w_lr_fire = 1'b0;
  assign w_lr_hold = 1'b0;
`endif

  // Next-state and datapath decode; swdi is used on rises, swdo/swdoe change on falls
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_hdr_nxt        = r_hdr;
    w_wpar_nxt       = r_wpar;
    w_ack_nxt        = r_ack;
    w_rdata_nxt      = r_rdata;
    w_wshift_nxt     = r_wshift;
    w_swdo_nxt       = r_swdo;
    w_swdoe_nxt      = r_swdoe;
    w_req_valid_nxt  = 1'b0;
    w_req_apndp_nxt  = r_req_apndp;
    w_req_rnw_nxt    = r_req_rnw;
    w_req_addr_nxt   = r_req_addr;
    w_wr_valid_nxt   = 1'b0;
    w_wr_data_nxt    = r_wr_data;
    w_wr_perr_nxt    = r_wr_perr;
    w_line_reset_nxt = 1'b0;
    w_ack_sel        = resp_valid ? resp_ack : L_ACK_WAIT;
    w_wr_ok          = (r_ack == L_ACK_OK) && !r_req_rnw;

    case (r_state)
      ST_IDLE: begin
        if (w_rise && w_sdi && !w_lr_hold) begin
          w_state_nxt = ST_HDR;
          w_cnt_nxt   = 6'd1;
          w_hdr_nxt   = 6'd0;
          w_wpar_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = 6'd0;
        end
      end
      // r_hdr collects APnDP..stop; the park bit is judged live on its own rise
      ST_HDR: begin
        if (w_rise && (r_cnt == 6'd7)) begin
          w_cnt_nxt = 6'd0;
          if (!r_hdr[5] && w_sdi && (r_hdr[4] == f_par4(r_hdr[3:0]))) begin
            w_state_nxt     = ST_TRN1;
            w_req_valid_nxt = 1'b1;
            w_req_apndp_nxt = r_hdr[0];
            w_req_rnw_nxt   = r_hdr[1];
            w_req_addr_nxt  = {r_hdr[3], r_hdr[2]};
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_rise) begin
          w_hdr_nxt = {w_sdi, r_hdr[5:1]};
          w_cnt_nxt = r_cnt + 6'd1;
        end else begin
          w_hdr_nxt = r_hdr;
        end
      end
      ST_TRN1: begin
        if (w_fall && (r_cnt == L_TURN)) begin
          w_ack_nxt   = w_ack_sel;
          w_rdata_nxt = resp_rdata;
          w_swdoe_nxt = 1'b1;
          w_swdo_nxt  = w_ack_sel[0];
          w_cnt_nxt   = 6'd1;
          w_state_nxt = ST_ACK;
        end else if (w_fall) begin
          w_cnt_nxt = r_cnt + 6'd1;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_ACK: begin
        if (w_fall && (r_cnt < 6'd3)) begin
          w_swdo_nxt = r_ack[r_cnt[1:0]];
          w_cnt_nxt  = r_cnt + 6'd1;
        end else if (w_fall && (r_ack == L_ACK_OK) && r_req_rnw) begin
          w_swdo_nxt  = r_rdata[0];
          w_cnt_nxt   = 6'd1;
          w_state_nxt = ST_RDATA;
        end else if (w_fall) begin
          w_swdoe_nxt = 1'b0;
          w_swdo_nxt  = 1'b1;
          w_cnt_nxt   = 6'd0;
          w_state_nxt = ST_TRN2;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_RDATA: begin
        if (w_fall && (r_cnt < 6'd32)) begin
          w_swdo_nxt = r_rdata[r_cnt[4:0]];
          w_cnt_nxt  = r_cnt + 6'd1;
        end else if (w_fall && (r_cnt == 6'd32)) begin
          w_swdo_nxt = f_par32(r_rdata);
          w_cnt_nxt  = 6'd33;
        end else if (w_fall) begin
          w_swdoe_nxt = 1'b0;
          w_swdo_nxt  = 1'b1;
          w_cnt_nxt   = 6'd0;
          w_state_nxt = ST_TRN2;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_TRN2: begin
        if (w_fall && (r_cnt == L_TURN_M1)) begin
          w_cnt_nxt   = 6'd0;
          w_state_nxt = w_wr_ok ? ST_WDATA : ST_IDLE;
        end else if (w_fall) begin
          w_cnt_nxt = r_cnt + 6'd1;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      // wr_valid fires even on a parity error; the consumer discards such data
      ST_WDATA: begin
        if (w_rise && (r_cnt < 6'd32)) begin
          w_wshift_nxt[r_cnt[4:0]] = w_sdi;
          w_wpar_nxt               = r_wpar ^ w_sdi;
          w_cnt_nxt                = r_cnt + 6'd1;
        end else if (w_rise) begin
          w_wr_valid_nxt = 1'b1;
          w_wr_data_nxt  = r_wshift;
          w_wr_perr_nxt  = r_wpar ^ w_sdi;
          w_cnt_nxt      = 6'd0;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 6'd0;
        w_swdoe_nxt = 1'b0;
        w_swdo_nxt  = 1'b1;
      end
    endcase

    if (w_lr_fire) begin
      w_state_nxt      = ST_IDLE;
      w_cnt_nxt        = 6'd0;
      w_swdoe_nxt      = 1'b0;
      w_swdo_nxt       = 1'b1;
      w_req_valid_nxt  = 1'b0;
      w_line_reset_nxt = 1'b1;
    end else begin
      w_line_reset_nxt = 1'b0;
    end

    w_idle_nxt = (w_state_nxt == ST_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 6'd0;
      r_hdr        <= 6'd0;
      r_wpar       <= 1'b0;
      r_ack        <= 3'd0;
      r_rdata      <= 32'd0;
      r_wshift     <= 32'd0;
      r_swdo       <= 1'b1;
      r_swdoe      <= 1'b0;
      r_req_valid  <= 1'b0;
      r_req_apndp  <= 1'b0;
      r_req_rnw    <= 1'b0;
      r_req_addr   <= 2'd0;
      r_wr_valid   <= 1'b0;
      r_wr_data    <= 32'd0;
      r_wr_perr    <= 1'b0;
      r_line_reset <= 1'b0;
      r_idle       <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hdr        <= w_hdr_nxt;
      r_wpar       <= w_wpar_nxt;
      r_ack        <= w_ack_nxt;
      r_rdata      <= w_rdata_nxt;
      r_wshift     <= w_wshift_nxt;
      r_swdo       <= w_swdo_nxt;
      r_swdoe      <= w_swdoe_nxt;
      r_req_valid  <= w_req_valid_nxt;
      r_req_apndp  <= w_req_apndp_nxt;
      r_req_rnw    <= w_req_rnw_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_wr_valid   <= w_wr_valid_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_wr_perr    <= w_wr_perr_nxt;
      r_line_reset <= w_line_reset_nxt;
      r_idle       <= w_idle_nxt;
    end
  end

  assign swdo       = r_swdo;
  assign swdoe      = r_swdoe;
  assign req_valid  = r_req_valid;
  assign req_apndp  = r_req_apndp;
  assign req_rnw    = r_req_rnw;
  assign req_addr32 = r_req_addr;
  assign wr_valid   = r_wr_valid;
  assign wr_data    = r_wr_data;
  assign wr_perr    = r_wr_perr;
  assign line_reset = r_line_reset;
  assign idle       = r_idle;

endmodule

// File: tb/tb_swd_target.sv
// Scoreboard bench for swd_target: a host model bit-bangs swclk/swdio, expected results are queued
// when a transfer is issued and compared when the target produces them.
module tb_swd_target;

  logic        clk = 1'b0;
  logic        rst, swclk_in, swdi;
  logic        swdo, swdoe, req_valid, req_apndp, req_rnw;
  logic [1:0]  req_addr32;
  logic        resp_valid;
  logic [2:0]  resp_ack;
  logic [31:0] resp_rdata;
  logic        wr_valid, wr_perr, line_reset, idle;
  logic [31:0] wr_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]  q_req[$];
  logic [32:0] q_wr[$];
  logic [32:0] q_rd[$];
  int          q_lr[$];
  int          lr_idx = 0;
  logic [3:0]  exp_req;
  logic [32:0] exp_wr;
  int          exp_lr;

  always #5 clk = ~clk;

  swd_target #(.TURN(1), .SYNC(2)) dut (
    .clk(clk), .rst(rst), .swclk_in(swclk_in), .swdi(swdi),
    .swdo(swdo), .swdoe(swdoe),
    .req_valid(req_valid), .req_apndp(req_apndp), .req_rnw(req_rnw), .req_addr32(req_addr32),
    .resp_valid(resp_valid), .resp_ack(resp_ack), .resp_rdata(resp_rdata),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_perr(wr_perr),
    .line_reset(line_reset), .idle(idle)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One swclk period: drive swdi, rise, sample what the target drove on the previous fall, fall.
  task automatic sw_bit(input logic din, output logic dout, output logic doe);
    swdi = din;
    repeat (4) @(negedge clk);
    swclk_in = 1'b1;
    repeat (4) @(negedge clk);
    dout = swdo;
    doe  = swdoe;
    swclk_in = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] hdr, input logic rv, input logic [2:0] ack,
                      input logic [31:0] rdata, input logic [31:0] wdata, input logic wpar);
    logic d, e, doe_all, doe_any, rnw;
    logic [2:0]  eff_ack, got_ack;
    logic [31:0] got_data;
    logic [32:0] exp_rd;
    resp_valid = rv;
    resp_ack   = ack;
    resp_rdata = rdata;
    rnw        = hdr[2];
    eff_ack    = rv ? ack : 3'b010;
    q_req.push_back({hdr[1], hdr[2], hdr[4], hdr[3]});
    if (eff_ack == 3'b001 && rnw) q_rd.push_back({^rdata, rdata});
    if (eff_ack == 3'b001 && !rnw) q_wr.push_back({(^wdata) ^ wpar, wdata});
    for (int i = 0; i < 8; i++) sw_bit(hdr[i], d, e);
    sw_bit(1'b0, d, e);
    check_eq("trn1_doe", 64'(e), 64'd0);
    doe_all = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sw_bit(1'b0, d, e);
      got_ack[i] = d;
      doe_all &= e;
    end
    check_eq("ack_bits", 64'(got_ack), 64'(eff_ack));
    check_eq("ack_doe", 64'(doe_all), 64'd1);
    if (eff_ack == 3'b001 && rnw) begin
      for (int i = 0; i < 32; i++) begin
        sw_bit(1'b0, d, e);
        got_data[i] = d;
        doe_all &= e;
      end
      sw_bit(1'b0, d, e);
      doe_all &= e;
      exp_rd = q_rd.pop_front();
      check_eq("rd_data", 64'(got_data), 64'(exp_rd[31:0]));
      check_eq("rd_parity", 64'(d), 64'(exp_rd[32]));
      check_eq("rd_doe", 64'(doe_all), 64'd1);
      sw_bit(1'b0, d, e);
      check_eq("rd_release", 64'(e), 64'd0);
    end else if (eff_ack == 3'b001) begin
      sw_bit(1'b0, d, e);
      check_eq("wr_release", 64'(e), 64'd0);
      doe_any = 1'b0;
      for (int i = 0; i < 32; i++) begin
        sw_bit(wdata[i], d, e);
        doe_any |= e;
      end
      sw_bit(wpar, d, e);
      doe_any |= e;
      check_eq("wr_doe", 64'(doe_any), 64'd0);
    end else begin
      sw_bit(1'b0, d, e);
      check_eq("nodata_release", 64'(e), 64'd0);
    end
    sw_bit(1'b0, d, e);
    check_eq("idle_after", 64'(idle), 64'd1);
    check_eq("swdo_idle", 64'(swdo), 64'd1);
  endtask

  // Output side of the scoreboard: each pulse pops and checks one expected entry
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid) begin
        if (q_req.size() == 0) check_eq("req_unexpected", 64'(req_valid), 64'd0);
        else begin
          exp_req = q_req.pop_front();
          check_eq("req_fields", 64'({req_apndp, req_rnw, req_addr32}), 64'(exp_req));
        end
      end
      if (wr_valid) begin
        if (q_wr.size() == 0) check_eq("wr_unexpected", 64'(wr_valid), 64'd0);
        else begin
          exp_wr = q_wr.pop_front();
          check_eq("wr_result", 64'({wr_perr, wr_data}), 64'(exp_wr));
        end
      end
      if (line_reset) begin
        if (q_lr.size() == 0) check_eq("lr_unexpected", 64'(line_reset), 64'd0);
        else begin
          exp_lr = q_lr.pop_front();
          check_eq("lr_rise_index", 64'(lr_idx), 64'(exp_lr));
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic d, e, doe_any;
    logic [7:0]  hdr;
    logic [31:0] rd;
    rst = 1'b1; swclk_in = 1'b0; swdi = 1'b0;
    resp_valid = 1'b0; resp_ack = 3'd0; resp_rdata = 32'd0;
    repeat (5) @(negedge clk);
    check_eq("rst_swdoe", 64'(swdoe), 64'd0);
    check_eq("rst_swdo", 64'(swdo), 64'd1);
    check_eq("rst_idle", 64'(idle), 64'd1);
    check_eq("rst_pulses", 64'({req_valid, wr_valid, line_reset}), 64'd0);
    check_eq("rst_req", 64'({req_apndp, req_rnw, req_addr32}), 64'd0);
    check_eq("rst_wr", 64'({wr_perr, wr_data}), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    xfer(8'hA5, 1'b1, 3'b001, 32'h12345678, 32'd0, 1'b0);
    xfer(8'h8B, 1'b1, 3'b001, 32'd0, 32'hDEADBEEF, 1'b0);
    xfer(8'h8B, 1'b1, 3'b001, 32'd0, 32'hDEADBEEF, 1'b1);

    // Header with a wrong parity bit: never answered
    hdr = 8'h85;
    doe_any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sw_bit(hdr[i], d, e);
      doe_any |= e;
    end
    check_eq("bad_hdr_idle", 64'(idle), 64'd1);
    for (int i = 0; i < 5; i++) begin
      sw_bit(1'b0, d, e);
      doe_any |= e;
    end
    check_eq("bad_hdr_doe", 64'(doe_any), 64'd0);

    xfer(8'hA5, 1'b0, 3'b001, 32'h0BADF00D, 32'd0, 1'b0);
    xfer(8'h8B, 1'b1, 3'b100, 32'd0, 32'h55AA55AA, 1'b0);

    // Long run of ones entered mid-header
`ifdef SWDT_LINERESET_EN
    q_lr.push_back(50);
`endif
    sw_bit(1'b1, d, e);
    sw_bit(1'b0, d, e);
    sw_bit(1'b0, d, e);
    doe_any = 1'b0;
    for (int i = 1; i <= 56; i++) begin
      lr_idx = i;
      sw_bit(1'b1, d, e);
      doe_any |= e;
`ifdef SWDT_LINERESET_EN
      if (i == 50) check_eq("lr_idle", 64'(idle), 64'd1);
`endif
    end
    for (int i = 0; i < 8; i++) begin
      lr_idx = 0;
      sw_bit(1'b0, d, e);
      doe_any |= e;
    end
    check_eq("ones_doe", 64'(doe_any), 64'd0);
    check_eq("ones_idle", 64'(idle), 64'd1);
    xfer(8'hA5, 1'b1, 3'b001, 32'h0F0F1234, 32'd0, 1'b0);

    // Reset while the target is driving read data bit 10
    hdr = 8'hA5;
    rd  = 32'hCAFEF00D;
    resp_valid = 1'b1; resp_ack = 3'b001; resp_rdata = rd;
    q_req.push_back({hdr[1], hdr[2], hdr[4], hdr[3]});
    for (int i = 0; i < 8; i++) sw_bit(hdr[i], d, e);
    for (int i = 9; i <= 22; i++) sw_bit(1'b0, d, e);
    repeat (4) @(negedge clk);
    check_eq("pre_rst_bit10", 64'({swdoe, swdo}), 64'({1'b1, rd[10]}));
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_swdoe", 64'(swdoe), 64'd0);
    check_eq("mid_rst_swdo", 64'(swdo), 64'd1);
    check_eq("mid_rst_idle", 64'(idle), 64'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    xfer(8'hA5, 1'b1, 3'b001, $urandom, 32'd0, 1'b0);
    xfer(8'h8B, 1'b1, 3'b001, 32'd0, $urandom, 1'($urandom_range(1, 0)));

    repeat (8) @(negedge clk);
    check_eq("q_req_drained", 64'(q_req.size()), 64'd0);
    check_eq("q_wr_drained", 64'(q_wr.size()), 64'd0);
    check_eq("q_lr_drained", 64'(q_lr.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
